// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU even-pipe issue logic.
package spu_pkg;

  localparam int unsigned MAX_LAT = 7;
  localparam int unsigned REG_W   = 7;
  localparam int unsigned ID_W    = 7;
  localparam int unsigned UNIT_W  = 3;
  localparam int unsigned LAT_W   = 4;

  localparam logic [UNIT_W-1:0] UNIT_FX1 = 3'b000;
  localparam logic [UNIT_W-1:0] UNIT_FX2 = 3'b001;
  localparam logic [UNIT_W-1:0] UNIT_FXB = 3'b010;
  localparam logic [UNIT_W-1:0] UNIT_FP6 = 3'b011;
  localparam logic [UNIT_W-1:0] UNIT_FP7 = 3'b100;
  localparam logic [UNIT_W-1:0] UNIT_FPD = 3'b101;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
  } slot_t;

  function automatic logic lat_legal(input logic [LAT_W-1:0] lat);
    return (lat != '0) && (int'(lat) <= int'(MAX_LAT));
  endfunction

endpackage

// File: rtl/even_wb_slot_tracker.sv
// Latency-indexed ring of pending register writebacks; slot 1 retires every edge.
module even_wb_slot_tracker
  import spu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             set_en,
  input  logic [LAT_W-1:0] set_lat,
  input  logic [REG_W-1:0] set_dst,
  input  logic [REG_W-1:0] ra_addr,
  input  logic [REG_W-1:0] rb_addr,
  input  logic [REG_W-1:0] rc_addr,
  output logic [MAX_LAT:2] slot_valid,
  output logic [MAX_LAT:2] dst_hit,
  output logic [MAX_LAT:2] ra_hit,
  output logic [MAX_LAT:2] rb_hit,
  output logic [MAX_LAT:2] rc_hit,
  output slot_t            retire_slot
);

  slot_t slot_q [1:MAX_LAT];
  slot_t slot_d [1:MAX_LAT];

  always_comb begin
    for (int k = 1; k < int'(MAX_LAT); k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[MAX_LAT] = '0;
    // The reservation lands after the shift, so slot L is relative to the new ring.
    if (set_en) begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        if (set_lat == LAT_W'(k)) begin
          slot_d[k] = '{valid: 1'b1, dst: set_dst};
        end
      end
    end
    if (flush) begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        slot_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Slot 1 is excluded: it retires at this edge and can never be a hazard.
  always_comb begin
    for (int k = 2; k <= int'(MAX_LAT); k++) begin
      slot_valid[k] = slot_q[k].valid;
      dst_hit[k]    = slot_q[k].valid && (slot_q[k].dst == set_dst);
      ra_hit[k]     = slot_q[k].valid && (slot_q[k].dst == ra_addr);
      rb_hit[k]     = slot_q[k].valid && (slot_q[k].dst == rb_addr);
      rc_hit[k]     = slot_q[k].valid && (slot_q[k].dst == rc_addr);
    end
  end

  assign retire_slot = slot_q[1];

endmodule

// File: rtl/even_issue_ctrl.sv
// Even-pipe issue scheduler: hazard checks, valid/ready handshake and registered issue.
module even_issue_ctrl
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ID_W-1:0]   in_instr_id,
  input  logic [UNIT_W-1:0] in_unit_id,
  input  logic [LAT_W-1:0]  in_latency,
  input  logic              in_reg_wr,
  input  logic [REG_W-1:0]  in_reg_dst,
  input  logic [REG_W-1:0]  in_ra_addr,
  input  logic [REG_W-1:0]  in_rb_addr,
  input  logic [REG_W-1:0]  in_rc_addr,
  input  logic              in_ra_used,
  input  logic              in_rb_used,
  input  logic              in_rc_used,
  output logic              issue_valid,
  output logic [ID_W-1:0]   issue_instr_id,
  output logic [UNIT_W-1:0] issue_unit_id,
  output logic [LAT_W-1:0]  issue_latency,
  output logic              issue_reg_wr,
  output logic [REG_W-1:0]  issue_reg_dst,
  output logic              wb_expect_valid,
  output logic [REG_W-1:0]  wb_expect_dst,
  output logic              lat_err,
  output logic [15:0]       stall_cnt
);

  logic [MAX_LAT:2] slot_valid;
  logic [MAX_LAT:2] dst_hit;
  logic [MAX_LAT:2] ra_hit;
  logic [MAX_LAT:2] rb_hit;
  logic [MAX_LAT:2] rc_hit;
  slot_t            retire_slot;

  logic lat_ok;
  logic wb_hit;
  logic waw_hit;
  logic raw_hit;
  logic hazard;
  logic accept;
  logic set_en;

  assign lat_ok = lat_legal(in_latency);

  // Indices are pre-shift: current slot k becomes slot k-1 after this edge.
  always_comb begin
    wb_hit  = 1'b0;
    waw_hit = 1'b0;
    raw_hit = 1'b0;
    for (int k = 2; k <= int'(MAX_LAT); k++) begin
      if (slot_valid[k] && (int'(in_latency) == k - 1)) wb_hit = 1'b1;
      if (dst_hit[k] && (k > int'(in_latency))) waw_hit = 1'b1;
      if ((in_ra_used && ra_hit[k]) || (in_rb_used && rb_hit[k]) ||
          (in_rc_used && rc_hit[k])) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign hazard   = lat_ok && ((in_reg_wr && (wb_hit || waw_hit)) || raw_hit);
  assign in_ready = rst && !flush && !hazard;
  assign accept   = in_valid && in_ready;
  assign set_en   = accept && lat_ok && in_reg_wr;

  even_wb_slot_tracker u_tracker (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .set_en      (set_en),
    .set_lat     (in_latency),
    .set_dst     (in_reg_dst),
    .ra_addr     (in_ra_addr),
    .rb_addr     (in_rb_addr),
    .rc_addr     (in_rc_addr),
    .slot_valid  (slot_valid),
    .dst_hit     (dst_hit),
    .ra_hit      (ra_hit),
    .rb_hit      (rb_hit),
    .rc_hit      (rc_hit),
    .retire_slot (retire_slot)
  );

  assign wb_expect_valid = retire_slot.valid;
  assign wb_expect_dst   = retire_slot.dst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid    <= 1'b0;
      issue_instr_id <= '0;
      issue_unit_id  <= '0;
      issue_latency  <= '0;
      issue_reg_wr   <= 1'b0;
      issue_reg_dst  <= '0;
      lat_err        <= 1'b0;
      stall_cnt      <= '0;
    end else begin
      issue_valid <= accept && lat_ok;
      lat_err     <= accept && !lat_ok;
      if (accept && lat_ok) begin
        issue_instr_id <= in_instr_id;
        issue_unit_id  <= in_unit_id;
        issue_latency  <= in_latency;
        issue_reg_wr   <= in_reg_wr;
        issue_reg_dst  <= in_reg_dst;
      end
      if (in_valid && !in_ready && !flush && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_even_issue_ctrl.sv
// Scoreboard bench for even_issue_ctrl: tasks push expected issue/writeback/lat_err events.
module tb_even_issue_ctrl;
  import spu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_instr_id = '0;
  logic [2:0]  in_unit_id = '0;
  logic [3:0]  in_latency = '0;
  logic        in_reg_wr = 1'b0;
  logic [6:0]  in_reg_dst = '0;
  logic [6:0]  in_ra_addr = '0;
  logic [6:0]  in_rb_addr = '0;
  logic [6:0]  in_rc_addr = '0;
  logic        in_ra_used = 1'b0;
  logic        in_rb_used = 1'b0;
  logic        in_rc_used = 1'b0;
  logic        issue_valid;
  logic [6:0]  issue_instr_id;
  logic [2:0]  issue_unit_id;
  logic [3:0]  issue_latency;
  logic        issue_reg_wr;
  logic [6:0]  issue_reg_dst;
  logic        wb_expect_valid;
  logic [6:0]  wb_expect_dst;
  logic        lat_err;
  logic [15:0] stall_cnt;

  even_issue_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr_id     (in_instr_id),
    .in_unit_id      (in_unit_id),
    .in_latency      (in_latency),
    .in_reg_wr       (in_reg_wr),
    .in_reg_dst      (in_reg_dst),
    .in_ra_addr      (in_ra_addr),
    .in_rb_addr      (in_rb_addr),
    .in_rc_addr      (in_rc_addr),
    .in_ra_used      (in_ra_used),
    .in_rb_used      (in_rb_used),
    .in_rc_used      (in_rc_used),
    .issue_valid     (issue_valid),
    .issue_instr_id  (issue_instr_id),
    .issue_unit_id   (issue_unit_id),
    .issue_latency   (issue_latency),
    .issue_reg_wr    (issue_reg_wr),
    .issue_reg_dst   (issue_reg_dst),
    .wb_expect_valid (wb_expect_valid),
    .wb_expect_dst   (wb_expect_dst),
    .lat_err         (lat_err),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [6:0] id;
    logic [6:0] dst;
    logic [3:0] lat;
    logic [2:0] unit;
    logic       wr;
  } iss_t;

  typedef struct {
    int         due;
    logic [6:0] dst;
  } wb_t;

  iss_t exp_iss[$];
  wb_t  exp_wb[$];
  int   exp_err[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  iss_t mon_i;
  wb_t  mon_w;

  // cyc counts rising edges; an offer driven while cyc==n is accepted at edge n+1.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every cycle out of reset, each output must match its queue head.
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if (exp_iss.size() != 0 && exp_iss[0].due == cyc) begin
        mon_i = exp_iss.pop_front();
        if (issue_valid !== 1'b1 || issue_instr_id !== mon_i.id || issue_unit_id !== mon_i.unit ||
            issue_latency !== mon_i.lat || issue_reg_wr !== mon_i.wr ||
            issue_reg_dst !== mon_i.dst) begin
          n_bad++;
          $display("FAIL issue cyc=%0d got v=%b id=%0d unit=%0d lat=%0d wr=%b dst=%0d required v=1 id=%0d unit=%0d lat=%0d wr=%b dst=%0d",
                   cyc, issue_valid, issue_instr_id, issue_unit_id, issue_latency, issue_reg_wr,
                   issue_reg_dst, mon_i.id, mon_i.unit, mon_i.lat, mon_i.wr, mon_i.dst);
        end
      end else if (issue_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL issue_spurious cyc=%0d got v=%b required v=0", cyc, issue_valid);
      end
      n_cmp++;
      if (exp_wb.size() != 0 && exp_wb[0].due == cyc) begin
        mon_w = exp_wb.pop_front();
        if (wb_expect_valid !== 1'b1 || wb_expect_dst !== mon_w.dst) begin
          n_bad++;
          $display("FAIL wb_expect cyc=%0d got v=%b dst=%0d required v=1 dst=%0d",
                   cyc, wb_expect_valid, wb_expect_dst, mon_w.dst);
        end
      end else if (wb_expect_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL wb_spurious cyc=%0d got v=%b dst=%0d required v=0",
                 cyc, wb_expect_valid, wb_expect_dst);
      end
      n_cmp++;
      if (exp_err.size() != 0 && exp_err[0] == cyc) begin
        void'(exp_err.pop_front());
        if (lat_err !== 1'b1) begin
          n_bad++;
          $display("FAIL lat_err cyc=%0d got %b required 1", cyc, lat_err);
        end
      end else if (lat_err !== 1'b0) begin
        n_bad++;
        $display("FAIL lat_err_spurious cyc=%0d got %b required 0", cyc, lat_err);
      end
    end
  end

  task automatic drive(input logic v, input logic [6:0] id, input logic [3:0] lat,
                       input logic wr, input logic [6:0] dst, input logic [6:0] ra,
                       input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] used);
    @(negedge clk);
    flush       = 1'b0;
    in_valid    = v;
    in_instr_id = id;
    in_unit_id  = id[2:0];
    in_latency  = lat;
    in_reg_wr   = wr;
    in_reg_dst  = dst;
    in_ra_addr  = ra;
    in_rb_addr  = rb;
    in_rc_addr  = rc;
    in_ra_used  = used[0];
    in_rb_used  = used[1];
    in_rc_used  = used[2];
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 7'd0, 4'd1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
  endtask

  // Records what an accepted offer in the current cycle must produce later.
  task automatic push_exp(input logic [6:0] id, input logic [3:0] lat, input logic wr,
                          input logic [6:0] dst);
    wb_t w;
    int  i;
    if (lat == 4'd0 || lat > 4'd7) begin
      exp_err.push_back(cyc + 1);
    end else begin
      exp_iss.push_back('{due: cyc + 1, id: id, dst: dst, lat: lat, unit: id[2:0], wr: wr});
      if (wr) begin
        w.due = cyc + int'(lat);
        w.dst = dst;
        i = 0;
        while (i < exp_wb.size() && exp_wb[i].due < w.due) i++;
        exp_wb.insert(i, w);
      end
    end
  endtask

  task automatic clear_exp();
    exp_iss.delete();
    exp_wb.delete();
    exp_err.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    clear_exp();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    in_valid    = 1'b1;
    in_latency  = 4'd2;
    in_reg_wr   = 1'b1;
    in_reg_dst  = 7'd7;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || issue_valid !== 1'b0 || wb_expect_valid !== 1'b0 ||
        lat_err !== 1'b0 || stall_cnt !== 16'd0 || issue_instr_id !== 7'd0 ||
        issue_reg_dst !== 7'd0 || wb_expect_dst !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_state got rdy=%b iv=%b wv=%b le=%b sc=%0d id=%0d dst=%0d wd=%0d required all 0",
               in_ready, issue_valid, wb_expect_valid, lat_err, stall_cnt, issue_instr_id,
               issue_reg_dst, wb_expect_dst);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    reset_dut();
    drive(1'b1, 7'd1, 4'd2, 1'b1, 7'd7, 7'd0, 7'd0, 7'd0, 3'b000);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ready got %b required 1", in_ready);
    end
    push_exp(7'd1, 4'd2, 1'b1, 7'd7);
    idle(1);
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_reg_dst !== 7'd7) begin
      n_bad++;
      $display("FAIL basic_issue got v=%b dst=%0d required v=1 dst=7", issue_valid, issue_reg_dst);
    end
    idle(1);
    n_cmp++;
    if (wb_expect_valid !== 1'b1 || wb_expect_dst !== 7'd7) begin
      n_bad++;
      $display("FAIL basic_wb got v=%b dst=%0d required v=1 dst=7", wb_expect_valid, wb_expect_dst);
    end
    idle(2);
  endtask

  task automatic test_wb_conflict();
    reset_dut();
    drive(1'b1, 7'd2, 4'd5, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000);
    push_exp(7'd2, 4'd5, 1'b1, 7'd3);
    drive(1'b1, 7'd3, 4'd4, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wbc_stall got %b required 0", in_ready);
    end
    drive(1'b1, 7'd3, 4'd4, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wbc_accept got %b required 1", in_ready);
    end
    push_exp(7'd3, 4'd4, 1'b1, 7'd9);
    idle(1);
    n_cmp++;
    if (stall_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL wbc_stall_cnt got %0d required 1", stall_cnt);
    end
    idle(6);
  endtask

  task automatic test_raw();
    reset_dut();
    for (int src = 0; src < 3; src++) begin
      drive(1'b1, 7'(10 + src), 4'd6, 1'b1, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000);
      push_exp(7'(10 + src), 4'd6, 1'b1, 7'd10);
      for (int s = 0; s < 6; s++) begin
        // All three addresses alias dst; only the 'used' one may cause the hazard.
        drive(1'b1, 7'(20 + src), 4'd1, 1'b0, 7'd0, 7'd10, 7'd10, 7'd10, 3'(1 << src));
        n_cmp++;
        if (in_ready !== (s == 5)) begin
          n_bad++;
          $display("FAIL raw_ready src=%0d step=%0d got %b required %b", src, s, in_ready, s == 5);
        end
      end
      push_exp(7'(20 + src), 4'd1, 1'b0, 7'd0);
      idle(2);
    end
    n_cmp++;
    if (stall_cnt !== 16'd15) begin
      n_bad++;
      $display("FAIL raw_stall_cnt got %0d required 15", stall_cnt);
    end
  endtask

  task automatic test_waw();
    reset_dut();
    drive(1'b1, 7'd30, 4'd7, 1'b1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000);
    push_exp(7'd30, 4'd7, 1'b1, 7'd4);
    for (int s = 0; s < 6; s++) begin
      drive(1'b1, 7'd31, 4'd2, 1'b1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000);
      n_cmp++;
      if (in_ready !== (s == 5)) begin
        n_bad++;
        $display("FAIL waw_ready step=%0d got %b required %b", s, in_ready, s == 5);
      end
    end
    push_exp(7'd31, 4'd2, 1'b1, 7'd4);
    idle(3);
    n_cmp++;
    if (stall_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL waw_stall_cnt got %0d required 5", stall_cnt);
    end
  endtask

  task automatic test_illegal_lat();
    reset_dut();
    drive(1'b1, 7'd40, 4'd6, 1'b1, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000);
    push_exp(7'd40, 4'd6, 1'b1, 7'd5);
    // Would be a RAW/WAW hazard if latency were legal.
    drive(1'b1, 7'd41, 4'd0, 1'b1, 7'd5, 7'd5, 7'd5, 7'd5, 3'b111);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_lat0_ready got %b required 1", in_ready);
    end
    push_exp(7'd41, 4'd0, 1'b1, 7'd5);
    drive(1'b1, 7'd42, 4'd9, 1'b1, 7'd6, 7'd0, 7'd0, 7'd0, 3'b000);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_lat9_ready got %b required 1", in_ready);
    end
    push_exp(7'd42, 4'd9, 1'b1, 7'd6);
    idle(6);
  endtask

  task automatic test_back_to_back();
    logic [3:0] lat_t [6] = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd7, 4'd4};
    logic       wr_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [6:0] dst_t [6] = '{7'd30, 7'd31, 7'd31, 7'd32, 7'd33, 7'd34};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      // Entry 1 reads dst 30 while it sits in slot 1 (retiring, no hazard).
      drive(1'b1, 7'(50 + i), lat_t[i], wr_t[i], dst_t[i], (i == 1) ? 7'd30 : 7'd0, 7'd0,
            7'd0, (i == 1) ? 3'b001 : 3'b000);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready idx=%0d got %b required 1", i, in_ready);
      end
      push_exp(7'(50 + i), lat_t[i], wr_t[i], dst_t[i]);
    end
    idle(8);
  endtask

  task automatic test_flush_reset();
    logic [15:0] sc;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'(60 + i), 4'd7, 1'b1, 7'(50 + i), 7'd0, 7'd0, 7'd0, 3'b000);
      push_exp(7'(60 + i), 4'd7, 1'b1, 7'(50 + i));
    end
    sc = stall_cnt;
    @(negedge clk);
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_latency = 4'd2;
    in_reg_dst = 7'd55;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_ready got %b required 0", in_ready);
    end
    exp_wb.delete();
    idle(1);
    n_cmp++;
    if (stall_cnt !== sc) begin
      n_bad++;
      $display("FAIL flush_stall_cnt got %0d required %0d", stall_cnt, sc);
    end
    idle(9);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'(70 + i), 4'd7, 1'b1, 7'(60 + i), 7'd0, 7'd0, 7'd0, 3'b000);
      push_exp(7'(70 + i), 4'd7, 1'b1, 7'(60 + i));
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    clear_exp();
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || issue_valid !== 1'b0 || issue_instr_id !== 7'd0 ||
        issue_latency !== 4'd0 || issue_reg_dst !== 7'd0 || issue_reg_wr !== 1'b0 ||
        wb_expect_valid !== 1'b0 || lat_err !== 1'b0 || stall_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset got rdy=%b iv=%b id=%0d lat=%0d dst=%0d wr=%b wv=%b le=%b sc=%0d required all 0",
               in_ready, issue_valid, issue_instr_id, issue_latency, issue_reg_dst,
               issue_reg_wr, wb_expect_valid, lat_err, stall_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wb_conflict();
    test_raw();
    test_waw();
    test_illegal_lat();
    test_back_to_back();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
